// File: rtl/fixed_divider.sv
// rtl/fixed_divider.sv - sequential unsigned fixed-point restoring divider, y = (a << FIXED_POINT) / b
module fixed_divider #(
  parameter int C_WIDTH     = 32,
  parameter int FIXED_POINT = 8
) (
  input  logic               ctl_clk,
  input  logic               reset,
  input  logic [C_WIDTH-1:0] a,
  input  logic [C_WIDTH-1:0] b,
  input  logic               trigger,
  output logic               ready,
  output logic               done,
  output logic [C_WIDTH-1:0] y,
  output logic [C_WIDTH-1:0] rem,
  output logic               div_by_zero,
  output logic               overflow
);

  localparam int N  = C_WIDTH + FIXED_POINT;
  localparam int CW = $clog2(N + 1);
  localparam logic [CW-1:0] LAST_ITER = CW'(N - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CAL  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_q;
  logic [CW-1:0]      cnt_q;
  logic [N-1:0]       d_q;
  // The partial remainder is always below b between iterations, so its
  // extra top bit is zero there; only the trial value needs C_WIDTH+1 bits.
  logic [C_WIDTH-1:0] r_q;
  logic [N-1:0]       q_q;
  logic [C_WIDTH-1:0] b_q;
  logic               bz_q;
  logic               ready_q;
  logic               done_q;
  logic [C_WIDTH-1:0] y_q;
  logic [C_WIDTH-1:0] rem_q;
  logic               dbz_q;
  logic               ovf_q;

  logic [C_WIDTH:0]   t_d;
  logic [C_WIDTH:0]   sub_d;
  logic               ge_d;
  logic [C_WIDTH:0]   r_d;
  logic               hi_nz_d;

  // One restoring step: shift in the next dividend bit, subtract b if it fits.
  always_comb begin
    t_d     = {r_q, d_q[N-1]};
    sub_d   = t_d - {1'b0, b_q};
    ge_d    = (t_d >= {1'b0, b_q});
    r_d     = ge_d ? sub_d : t_d;
    hi_nz_d = |q_q[N-1:C_WIDTH];
  end

  // Handshake FSM, iteration datapath and registered result outputs.
  always_ff @(posedge ctl_clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      d_q     <= '0;
      r_q     <= '0;
      q_q     <= '0;
      b_q     <= '0;
      bz_q    <= 1'b0;
      ready_q <= 1'b0;
      done_q  <= 1'b0;
      y_q     <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          ready_q <= 1'b1;
          if (ready_q && trigger) begin
            ready_q <= 1'b0;
            b_q     <= b;
            d_q     <= {a, {FIXED_POINT{1'b0}}};
            r_q     <= '0;
            q_q     <= '0;
            cnt_q   <= '0;
            bz_q    <= (b == '0);
            state_q <= (b == '0) ? DONE : CAL;
          end
        end
        CAL: begin
          d_q <= {d_q[N-2:0], 1'b0};
          r_q <= C_WIDTH'(r_d);
          q_q <= {q_q[N-2:0], ge_d};
          if (cnt_q == LAST_ITER) begin
            cnt_q   <= '0;
            state_q <= DONE;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        DONE: begin
          done_q  <= 1'b1;
          ready_q <= 1'b1;
          state_q <= IDLE;
          if (bz_q) begin
            y_q   <= '1;
            rem_q <= '0;
            dbz_q <= 1'b1;
            ovf_q <= 1'b0;
          end else if (hi_nz_d) begin
            y_q   <= '1;
            rem_q <= r_q;
            dbz_q <= 1'b0;
            ovf_q <= 1'b1;
          end else begin
            y_q   <= q_q[C_WIDTH-1:0];
            rem_q <= r_q;
            dbz_q <= 1'b0;
            ovf_q <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          ready_q <= 1'b0;
        end
      endcase
    end
  end

  assign ready       = ready_q;
  assign done        = done_q;
  assign y           = y_q;
  assign rem         = rem_q;
  assign div_by_zero = dbz_q;
  assign overflow    = ovf_q;

endmodule

// File: tb/tb_fixed_divider.sv
// tb/tb_fixed_divider.sv - scoreboard bench for fixed_divider
module tb_fixed_divider;

  logic        ctl_clk = 1'b0;
  logic        reset   = 1'b1;
  logic [31:0] a       = '0;
  logic [31:0] b       = '0;
  logic        trigger = 1'b0;
  logic        ready;
  logic        done;
  logic [31:0] y;
  logic [31:0] rem;
  logic        div_by_zero;
  logic        overflow;

  fixed_divider #(.C_WIDTH(32), .FIXED_POINT(8)) dut (
    .ctl_clk    (ctl_clk),
    .reset      (reset),
    .a          (a),
    .b          (b),
    .trigger    (trigger),
    .ready      (ready),
    .done       (done),
    .y          (y),
    .rem        (rem),
    .div_by_zero(div_by_zero),
    .overflow   (overflow)
  );

  always #5 ctl_clk = ~ctl_clk;

  int cyc = 0;
  always @(posedge ctl_clk) cyc++;

  int n_vec  = 0;
  int n_fail = 0;

  typedef struct {
    logic [31:0] y;
    logic [31:0] rem;
    logic        dbz;
    logic        ovf;
    int          lat;
    int          acc;
  } exp_t;

  exp_t sb[$];
  logic done_prev = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    n_vec++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, want, cyc);
    end
  endtask

  function automatic exp_t model(input logic [31:0] av, input logic [31:0] bv);
    exp_t e;
    logic [39:0] w, q, r;
    w = {av, 8'h00};
    e.lat = 41;
    e.acc = 0;
    if (bv == 0) begin
      e.y = '1; e.rem = '0; e.dbz = 1'b1; e.ovf = 1'b0; e.lat = 1;
    end else begin
      q = w / {8'h00, bv};
      r = w % {8'h00, bv};
      e.dbz = 1'b0;
      e.ovf = |q[39:32];
      e.y   = e.ovf ? 32'hFFFF_FFFF : q[31:0];
      e.rem = r[31:0];
    end
    return e;
  endfunction

  // Monitor: every done pulse is compared against the oldest pending expectation.
  always @(negedge ctl_clk) begin
    exp_t e;
    if (done === 1'b1) begin
      check("done_width", {31'b0, done_prev}, 32'd0);
      if (sb.size() == 0) begin
        n_vec++;
        n_fail++;
        $display("FAIL unexpected_done: got done=1 at cycle %0d want no done", cyc);
      end else begin
        e = sb.pop_front();
        check("y", y, e.y);
        check("rem", rem, e.rem);
        check("div_by_zero", {31'b0, div_by_zero}, {31'b0, e.dbz});
        check("overflow", {31'b0, overflow}, {31'b0, e.ovf});
        check("latency", cyc - e.acc, e.lat);
        check("ready_at_done", {31'b0, ready}, 32'd1);
      end
    end
    done_prev = done;
  end

  // Issue one operation with hand-computed expectations; caller is at a negedge.
  task automatic issue(input logic [31:0] av, input logic [31:0] bv,
                       input logic [31:0] ey, input logic [31:0] er,
                       input logic edbz, input logic eovf, input int elat);
    exp_t e;
    int n = 0;
    while (ready !== 1'b1 && n < 200) begin
      @(negedge ctl_clk);
      n++;
    end
    if (n >= 200) begin
      n_vec++;
      n_fail++;
      $display("FAIL ready_timeout: got ready=%b want 1", ready);
    end
    a = av;
    b = bv;
    trigger = 1'b1;
    e.y = ey; e.rem = er; e.dbz = edbz; e.ovf = eovf; e.lat = elat; e.acc = cyc + 1;
    sb.push_back(e);
    @(negedge ctl_clk);
    trigger = 1'b0;
    a = $urandom;
    b = $urandom;
    check("ready_after_accept", {31'b0, ready}, 32'd0);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (sb.size() != 0 && n < 300) begin
      @(negedge ctl_clk);
      n++;
    end
    if (sb.size() != 0) begin
      n_vec++;
      n_fail++;
      $display("FAIL done_timeout: got %0d pending results want 0", sb.size());
      sb.delete();
    end
    @(negedge ctl_clk);
  endtask

  initial begin
    int accepts;
    int prev_acc;
    exp_t e;

    repeat (3) @(negedge ctl_clk);
    check("rst_ready", {31'b0, ready}, 32'd0);
    check("rst_done", {31'b0, done}, 32'd0);
    check("rst_y", y, 32'd0);
    check("rst_rem", rem, 32'd0);
    check("rst_dbz", {31'b0, div_by_zero}, 32'd0);
    check("rst_ovf", {31'b0, overflow}, 32'd0);
    reset = 1'b0;
    @(negedge ctl_clk);
    check("ready_after_reset", {31'b0, ready}, 32'd1);

    // 3.0 / 2.0 = 1.5
    issue(32'h0000_0300, 32'h0000_0200, 32'h0000_0180, 32'h0, 1'b0, 1'b0, 41);
    wait_idle();
    // 1.0 / 3.0 = 0x55 remainder 0x100
    issue(32'h0000_0100, 32'h0000_0300, 32'h0000_0055, 32'h0000_0100, 1'b0, 1'b0, 41);
    wait_idle();
    // divide by zero
    issue(32'h1234_5678, 32'h0, 32'hFFFF_FFFF, 32'h0, 1'b1, 1'b0, 1);
    wait_idle();
    // saturation
    issue(32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0, 1'b0, 1'b1, 41);
    wait_idle();

    // Reset 10 edges into an operation aborts it.
    issue(32'h0000_0300, 32'h0000_0200, 32'h0000_0180, 32'h0, 1'b0, 1'b0, 41);
    repeat (9) @(negedge ctl_clk);
    reset = 1'b1;
    void'(sb.pop_back());
    @(negedge ctl_clk);
    check("abort_ready", {31'b0, ready}, 32'd0);
    check("abort_done", {31'b0, done}, 32'd0);
    check("abort_y", y, 32'd0);
    reset = 1'b0;
    @(negedge ctl_clk);
    check("abort_ready_rise", {31'b0, ready}, 32'd1);
    repeat (50) @(negedge ctl_clk);
    issue(32'h0000_0600, 32'h0000_0200, 32'h0000_0300, 32'h0, 1'b0, 1'b0, 41);
    wait_idle();

    // Trigger held high, operands scrambled every cycle.
    accepts  = 0;
    prev_acc = -1;
    trigger  = 1'b1;
    for (int i = 0; i < 400 && accepts < 6; i++) begin
      a = $urandom;
      b = $urandom >> $urandom_range(8, 31);
      if (b == 0) b = 32'd1;
      if (ready === 1'b1) begin
        e = model(a, b);
        e.acc = cyc + 1;
        sb.push_back(e);
        if (prev_acc >= 0) check("accept_spacing", e.acc - prev_acc, 32'd42);
        prev_acc = e.acc;
        accepts++;
      end
      @(negedge ctl_clk);
    end
    trigger = 1'b0;
    if (accepts < 6) begin
      n_vec++;
      n_fail++;
      $display("FAIL held_trigger_accepts: got %0d want 6", accepts);
    end
    wait_idle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
